axi4s_downsizer: RTL and testbench



---
 rtl/axi4s_downsizer.sv | 131 +++++++++++++
 tb/tb_axi4s_downsizer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4s_downsizer.sv
// AXI4-Stream width down-converter.
// Each accepted wide beat is held in one register. A per-slice pending mask
// picks which narrow slices still have to go out, least-significant first.
// Slices whose tkeep bits are all zero are skipped.
module axi4s_downsizer #(
  parameter int unsigned S_TDATA_WIDTH = 32,
  parameter int unsigned M_TDATA_WIDTH = 8,
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned TDEST_WIDTH   = 1,
  parameter int unsigned TID_WIDTH     = 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [S_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [S_TDATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [TDEST_WIDTH-1:0]     s_axis_tdest,
  input  logic [TID_WIDTH-1:0]       s_axis_tid,
  input  logic                       s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [M_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [M_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [TDEST_WIDTH-1:0]     m_axis_tdest,
  output logic [TID_WIDTH-1:0]       m_axis_tid,
  output logic                       m_axis_tlast
);

  localparam int unsigned RATIO = S_TDATA_WIDTH / M_TDATA_WIDTH;
  localparam int unsigned SK    = S_TDATA_WIDTH / 8;
  localparam int unsigned MK    = M_TDATA_WIDTH / 8;

  logic [S_TDATA_WIDTH-1:0] data_q;
  logic [SK-1:0]            keep_q;
  logic [SK-1:0]            strb_q;
  logic [TUSER_WIDTH-1:0]   user_q;
  logic [TDEST_WIDTH-1:0]   dest_q;
  logic [TID_WIDTH-1:0]     id_q;
  logic                     last_q;
  logic [RATIO-1:0]         pending_q;
  logic [RATIO-1:0]         pending_next;
  logic [RATIO-1:0]         slice_nz;
  logic                     ready_en_q;
  logic                     single;
  logic                     s_fire;
  logic                     m_fire;

  // Exactly one slice left: the current slice is also the final one
  assign single        = (pending_q != '0) && ((pending_q & (pending_q - RATIO'(1))) == '0);
  assign m_axis_tvalid = |pending_q;
  assign m_axis_tlast  = last_q & single;
  assign m_axis_tuser  = user_q;
  assign m_axis_tdest  = dest_q;
  assign m_axis_tid    = id_q;
  assign s_axis_tready = ready_en_q & ((pending_q == '0) | (single & m_axis_tready));
  assign s_fire        = s_axis_tvalid & s_axis_tready;
  assign m_fire        = m_axis_tvalid & m_axis_tready;

  // Which slices of the incoming beat carry at least one kept byte
  always_comb begin
    slice_nz = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      slice_nz[i] = |s_axis_tkeep[i*MK +: MK];
    end
  end

  // Present the lowest pending slice; descending scan lets the lowest win
  always_comb begin
    m_axis_tdata = data_q[M_TDATA_WIDTH-1:0];
    m_axis_tkeep = keep_q[MK-1:0];
    m_axis_tstrb = strb_q[MK-1:0];
    for (int unsigned i = RATIO; i > 0; i--) begin
      if (pending_q[i-1]) begin
        m_axis_tdata = data_q[(i-1)*M_TDATA_WIDTH +: M_TDATA_WIDTH];
        m_axis_tkeep = keep_q[(i-1)*MK +: MK];
        m_axis_tstrb = strb_q[(i-1)*MK +: MK];
      end
    end
  end

  // Next pending mask: retire the sent slice, a new beat overrides it
  always_comb begin
    pending_next = pending_q;
    if (m_fire) begin
      pending_next = pending_q & (pending_q - RATIO'(1));
    end
    if (s_fire) begin
      if (slice_nz != '0) begin
        pending_next = slice_nz;
      end else if (s_axis_tlast) begin
        // all-null last beat still emits one empty slice to mark the boundary
        pending_next = RATIO'(1);
      end else begin
        pending_next = '0;
      end
    end
  end

  // Holding register, pending mask and post-reset ready enable
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_q     <= '0;
      keep_q     <= '0;
      strb_q     <= '0;
      user_q     <= '0;
      dest_q     <= '0;
      id_q       <= '0;
      last_q     <= 1'b0;
      pending_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      pending_q  <= pending_next;
      if (s_fire) begin
        data_q <= s_axis_tdata;
        keep_q <= s_axis_tkeep;
        strb_q <= s_axis_tstrb;
        user_q <= s_axis_tuser;
        dest_q <= s_axis_tdest;
        id_q   <= s_axis_tid;
        last_q <= s_axis_tlast;
      end
    end
  end

endmodule

// File: tb/tb_axi4s_downsizer.sv
// Testbench for axi4s_downsizer (32-bit to 8-bit).
// Fixed vectors, hand-written corner sequences and randomized traffic
// checked against a slice-expansion scoreboard.
module tb_axi4s_downsizer;

  localparam int unsigned SW = 32;
  localparam int unsigned MW = 8;
  localparam int unsigned SK = SW / 8;
  localparam int unsigned MK = MW / 8;
  localparam int unsigned R  = SW / MW;
  localparam int unsigned UW = 1;
  localparam int unsigned DW = 2;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [MW-1:0] data;
    logic [MK-1:0] keep;
    logic [MK-1:0] strb;
    logic [UW-1:0] user;
    logic [DW-1:0] dest;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  typedef struct {
    logic [SW-1:0] data;
    logic [SK-1:0] keep;
    logic [SK-1:0] strb;
    logic          last;
    logic [UW-1:0] user;
    logic [DW-1:0] dest;
    logic [IW-1:0] id;
    int            n;
    logic [SW-1:0] ebytes;
    logic [R-1:0]  ekeep;
    logic [R-1:0]  estrb;
  } vec_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_tvalid, s_tready, s_tlast;
  logic [SW-1:0] s_tdata;
  logic [SK-1:0] s_tkeep, s_tstrb;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] s_tdest;
  logic [IW-1:0] s_tid;
  logic          m_tvalid, m_tready, m_tlast;
  logic [MW-1:0] m_tdata;
  logic [MK-1:0] m_tkeep, m_tstrb;
  logic [UW-1:0] m_tuser;
  logic [DW-1:0] m_tdest;
  logic [IW-1:0] m_tid;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  beat_t obs_q[$];
  int    obs_cyc[$];
  beat_t exp_q[$];
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  logic  smp_valid, smp_sready, accepted;
  vec_t  vecs[6];

  axi4s_downsizer #(
    .S_TDATA_WIDTH(SW),
    .M_TDATA_WIDTH(MW),
    .TUSER_WIDTH  (UW),
    .TDEST_WIDTH  (DW),
    .TID_WIDTH    (IW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tstrb (s_tstrb),
    .s_axis_tuser (s_tuser),
    .s_axis_tdest (s_tdest),
    .s_axis_tid   (s_tid),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tstrb (m_tstrb),
    .m_axis_tuser (m_tuser),
    .m_axis_tdest (m_tdest),
    .m_axis_tid   (m_tid),
    .m_axis_tlast (m_tlast)
  );

  always #5 aclk = ~aclk;

  // Reference: every slice with a kept byte becomes one output beat, in
  // ascending order; an all-null last beat becomes one empty last beat.
  task automatic model_push();
    int    n;
    int    k;
    beat_t b;
    n = 0;
    for (int i = 0; i < int'(R); i++) if (s_tkeep[i*MK +: MK] != '0) n++;
    k = 0;
    for (int i = 0; i < int'(R); i++) begin
      if (s_tkeep[i*MK +: MK] != '0) begin
        b = {s_tdata[i*MW +: MW], s_tkeep[i*MK +: MK], s_tstrb[i*MK +: MK],
             s_tuser, s_tdest, s_tid, s_tlast && (k == n - 1)};
        exp_q.push_back(b);
        k++;
      end
    end
    if (n == 0 && s_tlast) begin
      b = {s_tdata[MW-1:0], {MK{1'b0}}, s_tstrb[MK-1:0], s_tuser, s_tdest, s_tid, 1'b1};
      exp_q.push_back(b);
    end
  endtask

  // One clock: sample at the falling edge, return just after the rising edge
  task automatic step();
    beat_t cur;
    @(negedge aclk);
    cur        = {m_tdata, m_tkeep, m_tstrb, m_tuser, m_tdest, m_tid, m_tlast};
    smp_valid  = m_tvalid;
    smp_sready = s_tready;
    accepted   = 1'b0;
    if (aresetn) begin
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || cur !== prev_beat) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b beat=%h, need valid=1 beat=%h", m_tvalid, cur, prev_beat);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = cur;
      if (m_tvalid && m_tready) begin
        obs_q.push_back(cur);
        obs_cyc.push_back(cyc);
      end
      accepted = s_tvalid && s_tready;
      if (accepted) model_push();
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
    @(posedge aclk);
    #1;
  endtask

  // Present a beat and wait for acceptance; caller lowers s_tvalid afterwards
  task automatic send_beat(input logic [SW-1:0] d, input logic [SK-1:0] k, input logic [SK-1:0] st,
                           input logic l, input logic [UW-1:0] u, input logic [DW-1:0] de,
                           input logic [IW-1:0] id, input bit rnd);
    bit done;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tstrb = st;
    s_tlast = l; s_tuser = u; s_tdest = de; s_tid = id;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      step();
      done = accepted;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no s_tready within 200 cycles, need acceptance");
    end
  endtask

  task automatic clear_q();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic compare_model(input string tag);
    beat_t o, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s_missing: got no output, need %h", tag, e);
      end else begin
        o = obs_q.pop_front();
        void'(obs_cyc.pop_front());
        if (o !== e) begin
          errors++;
          $display("FAIL %s_beat: got %h, need %h", tag, o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s_extra: got %0d surplus outputs, need 0", tag, obs_q.size());
    end
    clear_q();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, need completion");
    $fatal(1);
  end

  initial begin
    beat_t o, e;
    bit    pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    vecs[0] = '{32'hDDCCBBAA, 4'hF, 4'h5, 1'b1, 1'b1, 2'd2, 2'd3, 4, 32'hDDCCBBAA, 4'hF, 4'h5};
    vecs[1] = '{32'h44332211, 4'h5, 4'hF, 1'b1, 1'b0, 2'd1, 2'd1, 2, 32'h00003311, 4'h3, 4'h3};
    vecs[2] = '{32'hCAFEBABE, 4'h0, 4'hF, 1'b0, 1'b1, 2'd0, 2'd0, 0, 32'h00000000, 4'h0, 4'h0};
    vecs[3] = '{32'h12345678, 4'h0, 4'h1, 1'b1, 1'b1, 2'd0, 2'd2, 1, 32'h00000078, 4'h0, 4'h1};
    vecs[4] = '{32'h9A000000, 4'h8, 4'h8, 1'b0, 1'b0, 2'd3, 2'd0, 1, 32'h0000009A, 4'h1, 4'h1};
    vecs[5] = '{32'h11223344, 4'hA, 4'h2, 1'b1, 1'b1, 2'd1, 2'd1, 2, 32'h00001133, 4'h3, 4'h1};

    aresetn = 1'b0; m_tready = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tstrb = '0;
    s_tlast = 1'b0; s_tuser = '0; s_tdest = '0; s_tid = '0;

    // Reset state
    #12;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 ||
        {m_tdata, m_tkeep, m_tstrb, m_tuser, m_tdest, m_tid, m_tlast} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ready=%b data=%h last=%b, need all zero",
               m_tvalid, s_tready, m_tdata, m_tlast);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reset: got s_tready=%b m_tvalid=%b, need 1/0", s_tready, m_tvalid);
    end

    // Fixed vectors with free-running sink
    for (int v = 0; v < 6; v++) begin
      clear_q();
      m_tready = 1'b1;
      send_beat(vecs[v].data, vecs[v].keep, vecs[v].strb, vecs[v].last,
                vecs[v].user, vecs[v].dest, vecs[v].id, 1'b0);
      s_tvalid = 1'b0;
      if (vecs[v].n == 0) begin
        step();
        checks++;
        if (smp_sready !== 1'b1 || smp_valid !== 1'b0) begin
          errors++;
          $display("FAIL null_beat_v%0d: got s_tready=%b m_tvalid=%b, need 1/0", v, smp_sready, smp_valid);
        end
      end
      repeat (6) step();
      checks++;
      if (obs_q.size() != vecs[v].n) begin
        errors++;
        $display("FAIL vec%0d_count: got %0d beats, need %0d", v, obs_q.size(), vecs[v].n);
      end
      for (int k = 0; k < vecs[v].n && k < obs_q.size(); k++) begin
        e = {vecs[v].ebytes[8*k +: 8], vecs[v].ekeep[k], vecs[v].estrb[k],
             vecs[v].user, vecs[v].dest, vecs[v].id, vecs[v].last && (k == vecs[v].n - 1)};
        checks++;
        if (obs_q[k] !== e) begin
          errors++;
          $display("FAIL vec%0d_beat%0d: got %h, need %h", v, k, obs_q[k], e);
        end
      end
    end
    clear_q();

    // Slave ready timing on a full beat
    m_tready = 1'b1;
    send_beat(32'hDDCCBBAA, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    s_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (smp_valid !== 1'b1 || smp_sready !== (k == 3)) begin
        errors++;
        $display("FAIL ready_timing_%0d: got m_tvalid=%b s_tready=%b, need 1/%b", k, smp_valid, smp_sready, k == 3);
      end
    end
    repeat (2) step();
    compare_model("single");

    // Back-to-back beats must stream without a gap
    m_tready = 1'b1;
    send_beat(32'h03020100, 4'hF, 4'hF, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    send_beat(32'h07060504, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    s_tvalid = 1'b0;
    repeat (6) step();
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats, need 8", obs_q.size());
    end else begin
      checks++;
      if (obs_cyc[7] - obs_cyc[0] != 7) begin
        errors++;
        $display("FAIL b2b_gap: got span %0d cycles, need 7", obs_cyc[7] - obs_cyc[0]);
      end
      for (int k = 0; k < 8; k++) begin
        o = obs_q[k];
        checks++;
        if (o.data !== 8'(k) || o.last !== (k == 7)) begin
          errors++;
          $display("FAIL b2b_beat%0d: got data=%h last=%b, need data=%h last=%b", k, o.data, o.last, 8'(k), k == 7);
        end
      end
    end
    compare_model("b2b");

    // Backpressure pattern 1,0,0,1 with sideband
    m_tready = 1'b0;
    send_beat(32'hDDCCBBAA, 4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0);
    s_tvalid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      m_tready = pat[k % 4];
      step();
    end
    m_tready = 1'b1;
    repeat (2) step();
    compare_model("backpressure");

    // Reset in the middle of a beat
    m_tready = 1'b1;
    send_beat(32'hDDCCBBAA, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    s_tvalid = 1'b0;
    step(); step();
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got m_tvalid=%b s_tready=%b, need 0/0", m_tvalid, s_tready);
    end
    clear_q();
    step(); step();
    aresetn = 1'b1;
    step();
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got s_tready=%b m_tvalid=%b, need 1/0", s_tready, m_tvalid);
    end
    repeat (8) step();
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_discard: got %0d beats after reset, need 0", obs_q.size());
    end
    clear_q();

    // Randomized traffic against the scoreboard
    for (int b = 0; b < 200; b++) begin
      logic [SK-1:0] kp;
      kp = ($urandom_range(0, 4) == 0) ? '0 : SK'($urandom);
      send_beat(SW'($urandom), kp, SK'($urandom), 1'($urandom_range(0, 1)),
                UW'($urandom), DW'($urandom), IW'($urandom), 1'b1);
      s_tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        m_tready = 1'($urandom_range(0, 1));
        step();
      end
    end
    m_tready = 1'b1;
    repeat (10) step();
    compare_model("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
